seg_num_fmt: RTL
================

SEG_NUM_FMT -- requirements
Module: seg_num_fmt

Interface
REQ-001 Parameter BIN_W, default 20: width of the binary input value.
REQ-002 Parameter DEC_MAX, default 999_999: largest value shown in decimal mode.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: conversion request, sampled at rising edges of clk.
REQ-006 Port bin, input, BIN_W: unsigned value to display.
REQ-007 Port hex_mode, input, 1: 1 selects hexadecimal display, 0 selects decimal display.
REQ-008 Port lz_en, input, 1: 1 enables leading-zero blanking.
REQ-009 Port busy, output, 1: a conversion is in progress.
REQ-010 Port seg_din, output, 48: six display bytes; byte k is seg_din[8k+7:8k]; byte 0 is the least significant digit and byte 5 the most significant.
REQ-011 Port seg_din_vld, output, 1: single-cycle strobe that seg_din and seg_din_mask are updated.
REQ-012 Port seg_din_mask, output, 6: bit (5-k) = 1 blanks byte k.
REQ-013 Port ovf, output, 1: the last decimal request exceeded DEC_MAX.

Function
REQ-014 The block SHALL use an FSM with three states: IDLE, CONV and OUT.
REQ-015 In IDLE, start=1 SHALL capture bin, hex_mode and lz_en and raise busy on the next cycle.
REQ-016 While busy=1, start SHALL be ignored; this includes the OUT cycle.
REQ-017 For a decimal request with bin <= DEC_MAX, the FSM SHALL spend exactly BIN_W cycles in CONV, performing one double-dabble step per cycle (every BCD nibble >= 5 gets +3, then the shift register shifts left by 1), then enter OUT.
REQ-018 For a decimal request with bin > DEC_MAX, the FSM SHALL go directly from IDLE to OUT.
REQ-019 For a hex request, the FSM SHALL go directly from IDLE to OUT.
REQ-020 Latency, counted from the start-sampling edge to the cycle where seg_din_vld=1: BIN_W+1 cycles for a converting decimal request, 1 cycle for hex or overflow.
REQ-021 In OUT, seg_din, seg_din_mask and ovf SHALL be registered, seg_din_vld SHALL be 1 for exactly that cycle, and the FSM SHALL then return to IDLE with busy=0.
REQ-022 Decimal byte k SHALL be 8'h00..8'h09, the k-th BCD digit.
REQ-023 Hex byte k SHALL be nibble k of bin zero-extended to 24 bits, value 8'h00..8'h0F.
REQ-024 Overflow SHALL set ovf=1 and output bytes 5..3 = 8'h0E, "R" (8'h52), "R" (8'h52), and bytes 2..0 = 8'hFF.
REQ-025 On overflow, mask SHALL be 6'b111000, regardless of lz_en.
REQ-026 A non-overflow result SHALL set ovf=0.
REQ-027 With lz_en=1, every leading zero byte from byte 5 downward SHALL be blanked; byte 0 SHALL never be blanked.
REQ-028 With lz_en=0, mask SHALL be 6'b000000 (except on overflow).
REQ-029 seg_din, seg_din_mask and ovf SHALL hold their values between OUT cycles.
REQ-030 Input changes during CONV SHALL have no effect on the result.

Reset
REQ-031 While rst=1: the FSM SHALL be in IDLE, busy=0, seg_din_vld=0, seg_din=48'h0, seg_din_mask=6'b000000, ovf=0, and all internal shift registers and counters cleared.
REQ-032 Asserting rst during CONV SHALL abort the conversion with no seg_din_vld pulse.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-034 Decimal 123456, lz_en=1 -> vld 21 cycles after start; bytes 5..0 = 01 02 03 04 05 06; mask 6'b000000; ovf=0.
REQ-035 Decimal 42, lz_en=1 -> bytes 00 00 00 00 04 02, mask 6'b001111.
REQ-036 Decimal 0, lz_en=1 -> mask 6'b011111.
REQ-037 Decimal 0, lz_en=0 -> mask 6'b000000.
REQ-038 Decimal 1_000_000 -> vld 1 cycle after start; ovf=1; bytes 0E 52 52 FF FF FF; mask 6'b111000.
REQ-039 Hex 20'hABCDE, lz_en=1 -> vld 1 cycle after start; bytes 00 0A 0B 0C 0D 0E; mask 6'b000001.
REQ-040 start pulses at cycles 5 and 10 after a decimal start, then rst at cycle 12 -> no vld; busy=0; outputs hold reset values; the next start converts correctly.

Source files
------------

// File: rtl/seg_num_fmt.sv
// Six-digit display formatter: binary input to decimal (double-dabble) or hex bytes,
// with leading-zero blanking and a fixed "ERR" pattern for out-of-range decimal values.
module seg_num_fmt #(
  parameter int unsigned BIN_W   = 20,
  parameter int unsigned DEC_MAX = 999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  input  logic             hex_mode,
  input  logic             lz_en,
  output logic             busy,
  output logic [47:0]      seg_din,
  output logic             seg_din_vld,
  output logic [5:0]       seg_din_mask,
  output logic             ovf
);

  localparam int unsigned DIG_W = 24;
  localparam int unsigned SR_W  = BIN_W + DIG_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [47:0] ERR_BYTES = 48'h0E_52_52_FF_FF_FF;
  localparam logic [5:0]  ERR_MASK  = 6'b111000;

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic             lz_q;

  logic [DIG_W-1:0] bcd_adj_c;
  logic [SR_W-1:0]  sr_step_c;
  logic [DIG_W-1:0] bcd_fin_c;
  logic [DIG_W-1:0] hex_dig_c;
  logic             dec_ovf_c;

  // Spread six 4-bit digits into six zero-extended display bytes.
  function automatic logic [47:0] nib_bytes(input logic [DIG_W-1:0] d);
    logic [47:0] b;
    b = '0;
    for (int k = 0; k < 6; k++) begin
      b[8*k +: 8] = {4'h0, d[4*k +: 4]};
    end
    return b;
  endfunction

  // Blank zero bytes from the most significant end; byte 0 always stays lit.
  function automatic logic [5:0] lz_mask(input logic [47:0] d);
    logic [5:0] m;
    logic       leading;
    m       = '0;
    leading = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      if (leading && (d[8*k +: 8] == 8'h00)) begin
        m[5-k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
    return m;
  endfunction

  // One double-dabble step: +3 on every BCD digit >= 5, then shift left.
  always_comb begin
    bcd_adj_c = sr[SR_W-1 -: DIG_W];
    for (int k = 0; k < 6; k++) begin
      if (bcd_adj_c[4*k +: 4] >= 4'd5) begin
        bcd_adj_c[4*k +: 4] = bcd_adj_c[4*k +: 4] + 4'd3;
      end
    end
    sr_step_c = {bcd_adj_c, sr[BIN_W-1:0]} << 1;
    bcd_fin_c = sr_step_c[SR_W-1 -: DIG_W];
  end

  assign hex_dig_c = DIG_W'(bin);
  assign dec_ovf_c = (64'(bin) > 64'(DEC_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      lz_q         <= 1'b0;
      busy         <= 1'b0;
      seg_din      <= '0;
      seg_din_vld  <= 1'b0;
      seg_din_mask <= '0;
      ovf          <= 1'b0;
    end else begin
      seg_din_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            lz_q <= lz_en;
            if (hex_mode) begin
              seg_din      <= nib_bytes(hex_dig_c);
              seg_din_mask <= lz_en ? lz_mask(nib_bytes(hex_dig_c)) : 6'b000000;
              ovf          <= 1'b0;
              seg_din_vld  <= 1'b1;
              state        <= OUT;
            end else if (dec_ovf_c) begin
              seg_din      <= ERR_BYTES;
              seg_din_mask <= ERR_MASK;
              ovf          <= 1'b1;
              seg_din_vld  <= 1'b1;
              state        <= OUT;
            end else begin
              sr    <= {{DIG_W{1'b0}}, bin};
              cnt   <= '0;
              state <= CONV;
            end
          end
        end
        CONV: begin
          sr  <= sr_step_c;
          cnt <= cnt + CNT_W'(1);
          // Last step: publish the result straight from the stepped value.
          if (cnt == CNT_W'(BIN_W - 1)) begin
            seg_din      <= nib_bytes(bcd_fin_c);
            seg_din_mask <= lz_q ? lz_mask(nib_bytes(bcd_fin_c)) : 6'b000000;
            ovf          <= 1'b0;
            seg_din_vld  <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
